flash_fetch_spi: RTL and testbench

//  Instruction fetch stage directly downstream of program_counter. Takes the current PC and reads one

---
 rtl/uc_pkg.sv | 23 ++
 rtl/spi_sclk_gen.sv | 45 ++++
 rtl/flash_fetch_spi.sv | 152 +++++++++++++++
 tb/tb_flash_fetch_spi.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uc_pkg.sv
// Shared constants and FSM encoding for the SPI flash instruction fetch path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uc_pkg;

    // SPI NOR "READ" opcode (no dummy cycles)
    localparam logic [7:0] UC_CMD_READ    = 8'h03;
    // Instruction word width; two flash bytes per word
    localparam int         UC_INSTR_WIDTH = 16;
    // Flash byte-address width carried on the wire
    localparam int         UC_SPI_ADDR_W  = 24;
    // Command + address bits shifted out before data
    localparam int         UC_TX_BITS     = 8 + UC_SPI_ADDR_W;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_ADDR = 3'd2,
        ST_DATA = 3'd3,
        ST_DONE = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/spi_sclk_gen.sv
// SPI clock generator: CLK_DIV-cycle half periods, rise/fall strobes for the fetch FSM.
// Latency: first rising strobe CLK_DIV cycles after enable; strobes are combinational from state.
// Backpressure: none; disable or clear returns SCLK low and the divider to zero on the next edge.
module spi_sclk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic arst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_rise,
    output logic o_fall,
    output logic o_sclk
);

    localparam int            CW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_sclk;
    logic          w_half_done;

    // A strobe fires on the edge that completes a half period; the register flips on that same edge
    assign w_half_done = i_en && !i_clr && (r_cnt == CNT_MAX);
    assign o_rise      = w_half_done && !r_sclk;
    assign o_fall      = w_half_done &&  r_sclk;
    assign o_sclk      = r_sclk;

    // Half-period divider; parked low whenever the FSM is not shifting bits
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
        end else if (!i_en || i_clr) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
        end else if (w_half_done) begin
            r_cnt  <= '0;
            r_sclk <= ~r_sclk;
        end else begin
            r_cnt  <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/flash_fetch_spi.sv
// Instruction fetch: READ(0x03) + 24-bit byte address from SPI NOR flash, returns one 16-bit word.
// Latency: flash_ready pulses 96*CLK_DIV cycles after the accepting edge, then 1 cycle back in IDLE.
// Backpressure: fetch_req is only sampled in IDLE (no queueing); flush aborts an in-flight read.
module flash_fetch_spi
    import uc_pkg::*;
#(
    parameter int         ADDR_WIDTH  = 12,
    parameter int         INSTR_WIDTH = UC_INSTR_WIDTH,
    parameter int         CLK_DIV     = 2,
    parameter logic [7:0] CMD_READ    = UC_CMD_READ
) (
    input  logic                   clk,
    input  logic                   arst_n,
    input  logic [ADDR_WIDTH-1:0]  pc_addr,
    input  logic                   fetch_req,
    input  logic                   flush,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic                   flash_ready,
    output logic                   busy,
    output logic                   spi_cs_n,
    output logic                   spi_sclk,
    output logic                   spi_mosi,
    input  logic                   spi_miso
);

    fetch_state_e            r_state;
    logic [UC_TX_BITS-1:0]   r_tx;
    logic [INSTR_WIDTH-1:0]  r_rx;
    logic [INSTR_WIDTH-1:0]  r_instr;
    logic [4:0]              r_bit_cnt;
    logic                    r_cs_n;
    logic                    r_mosi;
    logic                    r_ready;
    logic                    r_busy;

    logic                     w_shift_en;
    logic                     w_rise;
    logic                     w_fall;
    logic [4:0]               w_last_bit;
    logic [UC_SPI_ADDR_W-1:0] w_byte_addr;

    // Word address -> byte address: two bytes per instruction word
    assign w_byte_addr = UC_SPI_ADDR_W'({pc_addr, 1'b0});

    // SCLK only runs while bits are being shifted
    assign w_shift_en = (r_state == ST_CMD) || (r_state == ST_ADDR) || (r_state == ST_DATA);

    // Index of the final bit of the current phase; the bit counter restarts at each phase boundary
    always_comb begin
        w_last_bit = 5'd0;
        case (r_state)
            ST_CMD:  w_last_bit = 5'd7;
            ST_ADDR: w_last_bit = 5'(UC_SPI_ADDR_W - 1);
            ST_DATA: w_last_bit = 5'(INSTR_WIDTH - 1);
            default: w_last_bit = 5'd0;
        endcase
    end

    spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk    (clk),
        .arst_n (arst_n),
        .i_en   (w_shift_en),
        .i_clr  (flush),
        .o_rise (w_rise),
        .o_fall (w_fall),
        .o_sclk (spi_sclk)
    );

    // Fetch FSM: launches the read, shifts cmd/addr on falling strobes, samples MISO on rising strobes
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state   <= ST_IDLE;
            r_tx      <= '0;
            r_rx      <= '0;
            r_instr   <= '0;
            r_bit_cnt <= '0;
            r_cs_n    <= 1'b1;
            r_mosi    <= 1'b0;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // Flush is irrelevant here; a coincident request is still accepted
                    if (fetch_req) begin
                        r_state   <= ST_CMD;
                        r_tx      <= {CMD_READ, w_byte_addr};
                        r_mosi    <= CMD_READ[7];
                        r_cs_n    <= 1'b0;
                        r_busy    <= 1'b1;
                        r_bit_cnt <= '0;
                    end
                end
                ST_CMD, ST_ADDR, ST_DATA: begin
                    if (flush) begin
                        r_state   <= ST_IDLE;
                        r_cs_n    <= 1'b1;
                        r_mosi    <= 1'b0;
                        r_busy    <= 1'b0;
                        r_bit_cnt <= '0;
                    end else begin
                        if (w_rise && (r_state == ST_DATA)) begin
                            r_rx <= {r_rx[INSTR_WIDTH-2:0], spi_miso};
                        end
                        if (w_fall) begin
                            // MOSI only moves on the falling edge, so it is stable at every rise
                            r_tx   <= {r_tx[UC_TX_BITS-2:0], 1'b0};
                            r_mosi <= r_tx[UC_TX_BITS-2];
                            if (r_bit_cnt == w_last_bit) begin
                                r_bit_cnt <= '0;
                                case (r_state)
                                    ST_CMD:  r_state <= ST_ADDR;
                                    ST_ADDR: r_state <= ST_DATA;
                                    default: begin
                                        // Last data bit was captured on the preceding rise
                                        r_state <= ST_DONE;
                                        r_cs_n  <= 1'b1;
                                        r_mosi  <= 1'b0;
                                        r_instr <= r_rx;
                                        r_ready <= 1'b1;
                                    end
                                endcase
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 5'd1;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    // Pulse is already out; flush has nothing left to cancel
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cs_n  <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign instr       = r_instr;
    assign flash_ready = r_ready;
    assign busy        = r_busy;
    assign spi_cs_n    = r_cs_n;
    assign spi_mosi    = r_mosi;

endmodule

// File: tb/tb_flash_fetch_spi.sv
// Bench for flash_fetch_spi: byte-addressed SPI NOR model plus word-level expectations.
// Latency: checks the 192-cycle fetch latency and 194-cycle back-to-back period at CLK_DIV=2.
// Backpressure: exercises flush, held fetch_req and asynchronous reset mid-transaction.
module tb_flash_fetch_spi;

    localparam int AW  = 12;
    localparam int DIV = 2;
    localparam int LAT = 96 * DIV;

    logic          clk = 1'b0;
    logic          arst_n = 1'b0;
    logic [AW-1:0] pc_addr = '0;
    logic          fetch_req = 1'b0;
    logic          flush = 1'b0;
    logic [15:0]   instr;
    logic          flash_ready;
    logic          busy;
    logic          spi_cs_n;
    logic          spi_sclk;
    logic          spi_mosi;
    logic          spi_miso = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    flash_fetch_spi #(
        .ADDR_WIDTH  (AW),
        .INSTR_WIDTH (16),
        .CLK_DIV     (DIV),
        .CMD_READ    (8'h03)
    ) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .pc_addr     (pc_addr),
        .fetch_req   (fetch_req),
        .flush       (flush),
        .instr       (instr),
        .flash_ready (flash_ready),
        .busy        (busy),
        .spi_cs_n    (spi_cs_n),
        .spi_sclk    (spi_sclk),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso)
    );

    always #5 clk = ~clk;

    // Flash contents, byte addressed
    logic [7:0]  flash_mem [0:8191];
    logic [47:0] m_sh = '0;
    int          m_bits = 0;
    int          m_bi = 0;
    logic [31:0] m_cmd = '0;
    logic [23:0] m_addr = '0;
    logic [7:0]  m_byte = '0;

    // Flash slave, mode 0: capture MOSI on SCLK rise, restart on deselect
    always @(posedge spi_sclk or posedge spi_cs_n) begin
        if (spi_cs_n) begin
            m_bits = 0;
        end else begin
            m_sh   = {m_sh[46:0], spi_mosi};
            m_bits = m_bits + 1;
            if (m_bits == 32) begin
                m_cmd  = m_sh[31:0];
                m_addr = m_sh[23:0];
            end
        end
    end

    // Flash slave: present the next data bit after each SCLK fall once the address is in
    always @(negedge spi_sclk or posedge spi_cs_n) begin
        if (spi_cs_n) begin
            spi_miso = 1'b0;
        end else if (m_bits >= 32 && m_bits < 48) begin
            m_bi     = m_bits - 32;
            m_byte   = flash_mem[13'(int'(m_addr) + m_bi / 8)];
            spi_miso = m_byte[3'(7 - (m_bi % 8))];
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_word(input logic [AW-1:0] pc);
        int a;
        a = int'(pc) * 2;
        return {flash_mem[a], flash_mem[a + 1]};
    endfunction

    logic [15:0] last_instr = '0;

    // One complete fetch with optional flush at accept and during the DONE cycle
    task automatic do_fetch(input logic [AW-1:0] pc, input bit fl_acc, input bit fl_done);
        int          lat;
        logic [15:0] exp;
        logic [31:0] exp_cmd;
        exp     = exp_word(pc);
        exp_cmd = 32'h0300_0000 + 32'(pc) * 2;
        @(negedge clk);
        pc_addr   = pc;
        fetch_req = 1'b1;
        flush     = fl_acc;
        @(posedge clk);
        #1;
        fetch_req = 1'b0;
        flush     = 1'b0;
        pc_addr   = AW'($urandom);
        @(negedge clk);
        chk("accept_busy_cs", 64'({busy, spi_cs_n}), 64'(2'b10));
        lat = 0;
        for (int n = 1; n <= 2 * LAT; n++) begin
            @(negedge clk);
            if (flash_ready) begin
                lat = n;
                break;
            end
        end
        chk("latency", 64'(lat), 64'(LAT));
        chk("instr", 64'(instr), 64'(exp));
        chk("mosi_stream", 64'(m_cmd), 64'(exp_cmd));
        chk("done_cs_sclk_busy", 64'({spi_cs_n, spi_sclk, busy}), 64'(3'b101));
        if (fl_done) flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("ready_single", 64'({flash_ready, busy}), 64'(2'b00));
        chk("instr_hold", 64'(instr), 64'(exp));
        last_instr = exp;
    endtask

    int          pulses[$];
    int          runs[$];
    int          run;
    int          n_rdy;
    logic [AW-1:0] rpc;

    initial begin
        for (int i = 0; i < 8192; i++) flash_mem[i] = 8'($urandom);
        flash_mem[13'h246] = 8'hA5;
        flash_mem[13'h247] = 8'h5A;

        // Reset state, idle with no request
        repeat (3) @(negedge clk);
        arst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("reset_idle", 64'({spi_cs_n, spi_sclk, flash_ready, busy, instr}),
                64'({1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}));
        end

        // Known word and the top of the PC range
        do_fetch(12'h123, 1'b0, 1'b0);
        chk("known_word", 64'(instr), 64'(16'hA55A));
        do_fetch(12'hFFF, 1'b0, 1'b0);
        chk("addr_top", 64'(m_addr), 64'(24'h001FFE));

        // Flush in the middle of the address phase (overall bit 28)
        @(negedge clk);
        pc_addr   = 12'h055;
        fetch_req = 1'b1;
        @(posedge clk);
        #1;
        fetch_req = 1'b0;
        repeat (28 * 2 * DIV + 1) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_abort", 64'({spi_cs_n, spi_sclk, busy}), 64'(3'b100));
        n_rdy = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (flash_ready) n_rdy++;
        end
        chk("flush_no_ready", 64'(n_rdy), 64'(0));
        chk("flush_instr_kept", 64'(instr), 64'(last_instr));
        do_fetch(12'h010, 1'b0, 1'b0);

        // Random addresses, flush coinciding with accept or with DONE
        for (int k = 0; k < 5; k++) begin
            rpc = AW'($urandom);
            do_fetch(rpc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // fetch_req held high: three back-to-back transactions
        @(negedge clk);
        pc_addr   = 12'h200;
        fetch_req = 1'b1;
        run = 0;
        for (int c = 0; c < 1000 && pulses.size() < 3; c++) begin
            @(negedge clk);
            if (spi_cs_n) run++;
            else if (run > 0) begin
                runs.push_back(run);
                run = 0;
            end
            if (flash_ready) begin
                pulses.push_back(c);
                chk("b2b_instr", 64'(instr), 64'(exp_word(12'h200)));
            end
        end
        fetch_req = 1'b0;
        chk("b2b_pulses", 64'(pulses.size()), 64'(3));
        if (pulses.size() == 3) begin
            chk("b2b_period1", 64'(pulses[1] - pulses[0]), 64'(LAT + 2));
            chk("b2b_period2", 64'(pulses[2] - pulses[1]), 64'(LAT + 2));
        end
        chk("b2b_gaps", 64'(runs.size()), 64'(2));
        if (runs.size() == 2) begin
            chk("b2b_gap1", 64'(runs[0]), 64'(2));
            chk("b2b_gap2", 64'(runs[1]), 64'(2));
        end
        repeat (4) @(negedge clk);
        chk("b2b_stopped", 64'({busy, spi_cs_n}), 64'(2'b01));
        last_instr = exp_word(12'h200);

        // Asynchronous reset during the data phase
        @(negedge clk);
        pc_addr   = 12'h3A7;
        fetch_req = 1'b1;
        @(posedge clk);
        #1;
        fetch_req = 1'b0;
        repeat (150) @(posedge clk);
        #2;
        arst_n = 1'b0;
        #1;
        chk("arst_async", 64'({spi_cs_n, spi_sclk, busy, flash_ready}), 64'(4'b1000));
        repeat (3) @(negedge clk);
        arst_n = 1'b1;
        n_rdy = 0;
        for (int c = 0; c < 250; c++) begin
            @(negedge clk);
            if (flash_ready) n_rdy++;
        end
        chk("arst_no_ready", 64'(n_rdy), 64'(0));
        chk("arst_instr_clear", 64'(instr), 64'(16'h0000));
        do_fetch(12'h3A7, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard stop so the run cannot hang
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1);
    end

endmodule
